// File: rtl/tlv5618_ch_sched_pkg.sv
// Shared types for the TLV5618 channel scheduler: FSM states, R1/R0 control codes, word packing.
package tlv5618_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] CTL_WR_A   = 2'b10;
    localparam logic [1:0] CTL_WR_B   = 2'b00;
    localparam logic [1:0] CTL_WR_BUF = 2'b01;

    // Control word layout on the wire: {R1, SPD, PWR, R0, D11..D0}
    function automatic logic [15:0] pack_word(
        input logic [1:0]  ctl,
        input logic        spd,
        input logic        pwr,
        input logic [11:0] data
    );
        return {ctl[1], spd, pwr, ctl[0], data};
    endfunction

endpackage

// File: rtl/tlv5618_ch_sched_if.sv
// Request side (two channels + mode bits) and driver side of the scheduler in one bundle.
interface tlv5618_ch_sched_if;

    logic [11:0] cha_data;
    logic        cha_valid;
    logic        cha_ready;
    logic [11:0] chb_data;
    logic        chb_valid;
    logic        chb_ready;
    logic        sync_en;
    logic        spd;
    logic        pwr_dn;
    logic [15:0] drv_set_data;
    logic        drv_set_go;
    logic        drv_set_done;
    logic        busy;
    logic        err;

    modport slave (
        input  cha_data, cha_valid, chb_data, chb_valid,
        input  sync_en, spd, pwr_dn, drv_set_done,
        output cha_ready, chb_ready, drv_set_data, drv_set_go, busy, err
    );

    modport master (
        output cha_data, cha_valid, chb_data, chb_valid,
        output sync_en, spd, pwr_dn, drv_set_done,
        input  cha_ready, chb_ready, drv_set_data, drv_set_go, busy, err
    );

endinterface

// File: rtl/tlv5618_ch_sched.sv
// Round-robin A/B scheduler feeding the TLV5618 driver; TLV_SCHED_TIMEOUT_EN adds a sticky frame watchdog.
// Latency: set_go in the 2nd cycle after an accept when idle with no gap pending.
// Backpressure: each channel has one holding slot; ready stays low until its frame's done.
module tlv5618_ch_sched
    import tlv5618_pkg::*;
#(
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    tlv5618_ch_sched_if.slave bus
);

    state_t      r_state, w_state_nxt;
    logic        r_pend_a, r_pend_b;
    logic [11:0] r_hold_a, r_hold_b;
    logic        r_last_b;
    logic [7:0]  r_gap;
    logic        r_sync, r_sync_first, r_gnt_a;
    logic        r_spd, r_pwr;
    logic [15:0] r_data;

    logic        w_start, w_second, w_fin, w_timeout;
    logic        w_sync_sel, w_gnt_a_sel;
    logic [15:0] w_word;

    assign w_sync_sel  = bus.sync_en & r_pend_a & r_pend_b;
    assign w_gnt_a_sel = r_pend_a & (~r_pend_b | r_last_b);
    assign w_word      = w_sync_sel  ? pack_word(CTL_WR_BUF, bus.spd, bus.pwr_dn, r_hold_b) :
                         w_gnt_a_sel ? pack_word(CTL_WR_A,   bus.spd, bus.pwr_dn, r_hold_a) :
                                       pack_word(CTL_WR_B,   bus.spd, bus.pwr_dn, r_hold_b);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_second    = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            IDLE: begin
                if ((r_gap == 8'd0) && (r_pend_a || r_pend_b)) begin
                    w_state_nxt = GO;
                    w_start     = 1'b1;
                end
            end
            GO: w_state_nxt = WAIT;
            WAIT: begin
                if (bus.drv_set_done) begin
                    if (r_sync && r_sync_first) begin
                        w_state_nxt = GO;
                        w_second    = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_fin       = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_fin       = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pend_a     <= 1'b0;
            r_pend_b     <= 1'b0;
            r_hold_a     <= '0;
            r_hold_b     <= '0;
            r_last_b     <= 1'b1;
            r_gap        <= '0;
            r_sync       <= 1'b0;
            r_sync_first <= 1'b0;
            r_gnt_a      <= 1'b0;
            r_spd        <= 1'b0;
            r_pwr        <= 1'b0;
            r_data       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_data       <= w_word;
                r_sync       <= w_sync_sel;
                r_sync_first <= w_sync_sel;
                r_gnt_a      <= w_gnt_a_sel;
                r_spd        <= bus.spd;
                r_pwr        <= bus.pwr_dn;
            end
            // Second half of a sync pair reuses the mode bits captured at grant.
            if (w_second) begin
                r_data       <= pack_word(CTL_WR_A, r_spd, r_pwr, r_hold_a);
                r_sync_first <= 1'b0;
            end
            if (w_fin) begin
                r_gap <= 8'(GAP_CYC);
                if (!r_sync) r_last_b <= ~r_gnt_a;
            end else if ((r_state == IDLE) && (r_gap != 8'd0)) begin
                r_gap <= r_gap - 8'd1;
            end
            if (w_fin && (r_sync || r_gnt_a)) begin
                r_pend_a <= 1'b0;
            end else if (bus.cha_valid && !r_pend_a) begin
                r_pend_a <= 1'b1;
                r_hold_a <= bus.cha_data;
            end
            if (w_fin && (r_sync || !r_gnt_a)) begin
                r_pend_b <= 1'b0;
            end else if (bus.chb_valid && !r_pend_b) begin
                r_pend_b <= 1'b1;
                r_hold_b <= bus.chb_data;
            end
        end
    end

`ifdef TLV_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_err;

    assign w_timeout = (r_state == WAIT) && !bus.drv_set_done && (r_wd == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != WAIT)        r_wd <= '0;
            else if (!bus.drv_set_done) r_wd <= r_wd + 1'b1;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    // No watchdog: WAIT holds until the driver reports done.
    assign w_timeout = (TIMEOUT_CYC < 0);
    assign bus.err   = 1'b0;
`endif

    assign bus.cha_ready    = ~r_pend_a;
    assign bus.chb_ready    = ~r_pend_b;
    assign bus.drv_set_data = r_data;
    assign bus.drv_set_go   = (r_state == GO);
    assign bus.busy         = (r_state != IDLE) | r_pend_a | r_pend_b;

endmodule

// File: tb/tb_tlv5618_ch_sched.sv
// Directed plus randomized check of the TLV5618 channel scheduler against a frame-order reference model.
module tb_tlv5618_ch_sched;

    localparam int GAP = 2;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   m_last_b = 1'b1;

    always #5 clk = ~clk;

    tlv5618_ch_sched_if bus();

    tlv5618_ch_sched #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 = single A, 1 = single B, 2 = sync buffer write
    function automatic logic [15:0] word(input int kind, input bit s, input bit p, input logic [11:0] d);
        int r1 = (kind == 0) ? 1 : 0;
        int r0 = (kind == 2) ? 1 : 0;
        return 16'((r1 << 15) + (int'(s) << 14) + (int'(p) << 13) + (r0 << 12) + int'(d));
    endfunction

    task automatic send(input bit av, input logic [11:0] ad, input bit bv, input logic [11:0] bd);
        bus.cha_valid = av;
        bus.cha_data  = ad;
        bus.chb_valid = bv;
        bus.chb_data  = bd;
        @(negedge clk);
        bus.cha_valid = 1'b0;
        bus.chb_valid = 1'b0;
    endtask

    task automatic wait_go(output int n);
        n = 0;
        while (bus.drv_set_go !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Serve one driver frame: expect go after exp_n cycles (skip if negative), hold for lat, then done.
    task automatic frame(input logic [15:0] w, input int exp_n, input string tag, input int lat);
        int n;
        wait_go(n);
        chk({tag, "_go"}, bus.drv_set_go, 1);
        if (exp_n >= 0) chk({tag, "_lat"}, 16'(n), 16'(exp_n));
        chk({tag, "_word"}, bus.drv_set_data, w);
        @(negedge clk);
        chk({tag, "_pulse"}, bus.drv_set_go, 0);
        repeat (lat) @(negedge clk);
        chk({tag, "_hold"}, bus.drv_set_data, w);
        bus.drv_set_done = 1'b1;
        @(negedge clk);
        bus.drv_set_done = 1'b0;
    endtask

    task automatic chk_rdy(input string tag, input bit a, input bit b);
        chk({tag, "_rdy_a"}, bus.cha_ready, 16'(a));
        chk({tag, "_rdy_b"}, bus.chb_ready, 16'(b));
    endtask

    // One request round predicted from the scheduling rules; entered one cycle after the previous done.
    task automatic round(input bit av, input logic [11:0] ad, input bit bv, input logic [11:0] bd,
                         input bit sy, input bit s, input bit p, input int idle);
        logic [15:0] wa, wb, wbuf;
        int n1;
        wa   = word(0, s, p, ad);
        wb   = word(1, s, p, bd);
        wbuf = word(2, s, p, bd);
        n1   = (GAP - idle > 1) ? GAP - idle : 1;
        repeat (idle) @(negedge clk);
        bus.sync_en = sy;
        bus.spd     = s;
        bus.pwr_dn  = p;
        send(av, ad, bv, bd);
        chk_rdy("acc", !av, !bv);
        if (av && bv && sy) begin
            frame(wbuf, n1, "sync1", $urandom_range(0, 5));
            chk_rdy("sync_mid", 0, 0);
            frame(wa, 0, "sync2", $urandom_range(0, 5));
        end else if (av && bv) begin
            if (m_last_b) begin
                frame(wa, n1, "rr_a1", $urandom_range(0, 5));
                chk_rdy("rr_mid", 1, 0);
                frame(wb, GAP + 1, "rr_b2", $urandom_range(0, 5));
                m_last_b = 1'b1;
            end else begin
                frame(wb, n1, "rr_b1", $urandom_range(0, 5));
                chk_rdy("rr_mid", 0, 1);
                frame(wa, GAP + 1, "rr_a2", $urandom_range(0, 5));
                m_last_b = 1'b0;
            end
        end else if (av) begin
            frame(wa, n1, "one_a", $urandom_range(0, 5));
            m_last_b = 1'b0;
        end else begin
            frame(wb, n1, "one_b", $urandom_range(0, 5));
            m_last_b = 1'b1;
        end
        chk_rdy("end", 1, 1);
        chk("end_busy", bus.busy, 0);
    endtask

    task automatic rnd_round();
        bit av, bv;
        int mode;
        mode = $urandom_range(0, 2);
        av = (mode != 1);
        bv = (mode != 0);
        round(av, 12'($urandom), bv, 12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 4));
    endtask

    initial begin
        int n;
        int gos;
        bus.cha_valid = 1'b0;
        bus.cha_data = '0;
        bus.chb_valid = 1'b0;
        bus.chb_data = '0;
        bus.sync_en = 1'b0;
        bus.spd = 1'b0;
        bus.pwr_dn = 1'b0;
        bus.drv_set_done = 1'b0;
        #3;
        chk_rdy("rst", 1, 1);
        chk("rst_go", bus.drv_set_go, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_data", bus.drv_set_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single A, fast mode
        bus.spd = 1'b1;
        send(1, 12'h7D0, 0, 12'h000);
        chk_rdy("a1_acc", 0, 1);
        frame(16'hC7D0, 1, "a1", 3);
        chk_rdy("a1_done", 1, 1);

        // Single B, slow mode, gap before issue
        bus.spd = 1'b0;
        send(0, 12'h000, 1, 12'h3E8);
        frame(16'h03E8, 2, "b1", 1);
        chk_rdy("b1_done", 1, 1);

        // Simultaneous requests without sync: round-robin
        send(1, 12'h111, 1, 12'h222);
        frame(16'h8111, 2, "ab1_a", 2);
        chk_rdy("ab1_mid", 1, 0);
        frame(16'h0222, GAP + 1, "ab1_b", 0);
        send(1, 12'h333, 1, 12'h444);
        frame(16'h8333, 2, "ab2_a", 1);
        frame(16'h0444, GAP + 1, "ab2_b", 1);
        send(1, 12'h555, 0, 12'h000);
        frame(16'h8555, 2, "a2", 0);
        send(1, 12'h666, 1, 12'h777);
        frame(16'h0777, 2, "ab3_b", 2);
        chk_rdy("ab3_mid", 0, 1);
        frame(16'h8666, GAP + 1, "ab3_a", 2);
        m_last_b = 1'b0;

        // Sync pair: buffer write then A, back to back
        bus.sync_en = 1'b1;
        send(1, 12'h123, 1, 12'h456);
        frame(16'h1456, 2, "sy_buf", 2);
        chk_rdy("sy_mid", 0, 0);
        frame(16'h8123, 0, "sy_a", 2);
        chk_rdy("sy_done", 1, 1);
        bus.sync_en = 1'b0;

        // Power-down bit
        bus.pwr_dn = 1'b1;
        send(1, 12'h0FF, 0, 12'h000);
        frame(16'hA0FF, 2, "pd", 1);
        bus.pwr_dn = 1'b0;
        m_last_b = 1'b0;

        for (int k = 0; k < 24; k++) rnd_round();

        // Asynchronous reset while the driver frame is in flight
        repeat (4) @(negedge clk);
        send(1, 12'hABC, 1, 12'hDEF);
        wait_go(n);
        chk("rw_go", bus.drv_set_go, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rdy("rw", 1, 1);
        chk("rw_go0", bus.drv_set_go, 0);
        chk("rw_busy", bus.busy, 0);
        chk("rw_data", bus.drv_set_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        m_last_b = 1'b1;
        gos = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            gos += int'(bus.drv_set_go);
        end
        chk("rw_nogo", 16'(gos), 16'd0);
        round(1, 12'h9AB, 1, 12'hCDE, 0, 1, 1, 3);

        // Driver never answers
        send(0, 12'h000, 1, 12'h5A5);
        wait_go(n);
        chk("wd_go", bus.drv_set_go, 1);
`ifdef TLV_SCHED_TIMEOUT_EN
        repeat (TMO) @(negedge clk);
        chk("wd_err_early", bus.err, 0);
        @(negedge clk);
        chk("wd_err", bus.err, 1);
        chk("wd_busy", bus.busy, 0);
        chk("wd_rdy_b", bus.chb_ready, 1);
`else
        gos = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gos += int'(bus.drv_set_go);
        end
        chk("wd_err", bus.err, 0);
        chk("wd_busy", bus.busy, 1);
        chk("wd_rdy_b", bus.chb_ready, 0);
        chk("wd_nogo", 16'(gos), 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlv5618_ch_sched.md
Name: tlv5618_ch_sched

Overview:
- Two-channel request scheduler in front of tlv5618_driver.
- Accepts independent 12-bit codes for DAC A and DAC B over valid/ready handshakes.
- Builds the TLV5618 16-bit control words, arbitrates round-robin and sequences the driver's set_go/set_done handshake.
- Optional simultaneous-update mode writes the B value to the DAC buffer, then writes A, so both outputs change on the same frame.

Parameters:
- GAP_CYC, 2: minimum idle clk cycles between drv_set_done and the next drv_set_go (CS high time). Range 0..255.
- TIMEOUT_CYC, 1024: watchdog limit in clk cycles for each driver frame. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cha_data  in  12  DAC A code
- cha_valid  in  1  A request valid
- cha_ready  out  1  A holding register free
- chb_data  in  12  DAC B code
- chb_valid  in  1  B request valid
- chb_ready  out  1  B holding register free
- sync_en  in  1  simultaneous-update mode
- spd  in  1  speed bit (1 = fast), copied into every word
- pwr_dn  in  1  power-down bit, copied into every word
- drv_set_data  out  16  word to driver set_data
- drv_set_go  out  1  one-cycle start pulse to driver set_go
- drv_set_done  in  1  one-cycle completion pulse from driver set_done
- busy  out  1  high whenever state != IDLE or any pend flag is set
- err  out  1  sticky watchdog flag; tied 0 when the feature is off

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except cha_ready=chb_ready=1. pend_a=pend_b=0, state=IDLE, gap counter=0, last_grant=B (so A wins the first tie). Any request in flight is discarded. drv_set_go drops immediately.
- Handshake:
  - cha_ready = ~pend_a, registered; same rule for B.
  - On a clk edge with valid&ready, the data is captured into hold_x and pend_x is set.
  - pend_x clears on the drv_set_done that completes the frame carrying hold_x. Ready rises the following cycle.
- Word format is {R1,SPD,PWR,R0,data[11:0]}, with spd/pwr_dn sampled in IDLE at grant:
  - single A: R1R0=10
  - single B: R1R0=00 (writes DAC B and buffer)
  - sync buffer write: R1R0=01
  - Because B writes also load the buffer, a single-A frame refreshes B with its current value.
- States:
  - IDLE → GO when gap==0 and any pend is set.
    - Grant rules: sync_en && pend_a && pend_b → sync pair, B-buffer word first. Otherwise the single pending channel. If both are pending without sync, the channel != last_grant.
    - drv_set_data is loaded on the IDLE→GO edge.
  - GO: drv_set_go=1 for exactly one cycle → WAIT.
  - WAIT: on drv_set_done:
    - if the sync pair's first frame just finished → GO with the A word;
    - else clear the granted pend(s), update last_grant, load gap=GAP_CYC → IDLE.
  - In sync mode both pend flags clear on the second done; last_grant is unchanged.
  - drv_set_data is held stable from GO until done.
- Latency: from the accepting edge with state IDLE and gap 0, drv_set_go is high in the 2nd cycle after that edge.
- drv_set_done outside WAIT is ignored. A new request while busy is held; a new same-channel request is blocked by ready.
- sync_en is sampled only at grant. A lone pending channel is served singly; it never waits for its partner.
- Gap counter counts down to 0 in IDLE. With GAP_CYC=0 there is back-to-back issue after 1 IDLE cycle.

Optional Feature:
- Macro TLV_SCHED_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT. On reaching TIMEOUT_CYC without drv_set_done, it sets err (sticky until reset) and clears the granted pend(s), including both pends for a sync pair.
  - The state then goes to IDLE with gap loaded.
- When undefined: no counter; err is constant 0; WAIT waits indefinitely.

Decomposition:
- Package tlv5618_pkg:
  - state enum (IDLE, GO, WAIT);
  - R1R0 constants (CTL_WR_A=2'b10, CTL_WR_B=2'b00, CTL_WR_BUF=2'b01);
  - word-pack function {r1,spd,pwr,r0,data}.
- Single module; no sub-module. The round-robin is one flag.

Test Plan:
- spd=1, pwr_dn=0, A=0x7D0 alone → drv_set_data=0xC7D0, one go pulse. cha_ready stays low until 1 cycle after done.
- spd=0, B=0x3E8 alone → 0x03E8. Gap of GAP_CYC cycles precedes any next go.
- Both valid in the same cycle, sync_en=0, A=0x111, B=0x222 → A frame 0x8111 first, then 0x0222. Repeat with both → alternation persists.
- sync_en=1, A=0x123, B=0x456, spd=0 → frames 0x1456 then 0x8123 with no gap between. Both readies rise together after the second done.
- pwr_dn=1, A=0x0FF → 0xA0FF. Reset asserted during WAIT → outputs and readies return to reset values asynchronously; no further go.
- TLV_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, drv_set_done held 0 → err=1 after 16 WAIT cycles, pend cleared, IDLE. Without the macro → err stays 0 and the block remains in WAIT.
